// File: rtl/division_scheduler.sv
// Round-robin front end that shares one Q8.8 division unit among N_REQ requesters.
// Optional WAIT watchdog enabled by defining DIV_TIMEOUT_EN (aborts with rsp_error).
module division_scheduler #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [16*N_REQ-1:0]   dividen_in,
    input  logic [16*N_REQ-1:0]   divisor_in,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [15:0]           rsp_result,
    output logic                  rsp_overflow,
    output logic                  rsp_error,
    output logic                  busy,
    output logic                  div_start,
    output logic [15:0]           div_dividen,
    output logic [15:0]           div_divisor,
    input  logic [15:0]           div_result,
    input  logic                  div_overflow,
    input  logic                  div_finish
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("division_scheduler: N_REQ must be 2..8 and TIMEOUT at least 1");
    end

    typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    int unsigned      slot;
    logic [15:0]      pick_dividen;
    logic [15:0]      pick_divisor;

`ifdef DIV_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign rsp_error = 1'b0;
`endif

    // First requester at or above ptr, searching with wrap-around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        slot  = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            slot = 32'(ptr) + k;
            if (slot >= N_REQ) begin
                slot = slot - N_REQ;
            end
            cand = IDX_W'(slot);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign pick_dividen = dividen_in[{pick, 4'b0000} +: 16];
    assign pick_divisor = divisor_in[{pick, 4'b0000} +: 16];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            winner       <= '0;
            grant        <= '0;
            rsp_valid    <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            busy         <= 1'b0;
            div_start    <= 1'b0;
            div_dividen  <= '0;
            div_divisor  <= '0;
`ifdef DIV_TIMEOUT_EN
            rsp_error    <= 1'b0;
            wait_cnt     <= '0;
`endif
        end else begin
            grant     <= '0;
            rsp_valid <= '0;
            div_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        winner      <= pick;
                        div_dividen <= pick_dividen;
                        div_divisor <= pick_divisor;
                        ptr         <= (pick == IDX_W'(N_REQ - 1)) ? '0 : pick + 1'b1;
                        grant       <= N_REQ'(1) << pick;
                        div_start   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= SETTLE;
                end
                // The divider's finish is still the previous operation's level here.
                SETTLE: begin
`ifdef DIV_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (div_finish) begin
                        rsp_result   <= div_result;
                        rsp_overflow <= div_overflow;
                        rsp_valid    <= N_REQ'(1) << winner;
                        state        <= DONE;
`ifdef DIV_TIMEOUT_EN
                        rsp_error    <= 1'b0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                        rsp_result   <= '0;
                        rsp_overflow <= 1'b0;
                        rsp_error    <= 1'b1;
                        rsp_valid    <= N_REQ'(1) << winner;
                        state        <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef DIV_TIMEOUT_EN
                    rsp_error <= 1'b0;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_division_scheduler.sv
// Bench for division_scheduler: divider emulator plus a transaction-level model checked every cycle.
`timescale 1ns/1ps
module tb_division_scheduler;

    localparam int N   = 4;
    localparam int TMO = 48;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [16*N-1:0] dividen_in;
    logic [16*N-1:0] divisor_in;
    logic [N-1:0]    grant;
    logic [N-1:0]    rsp_valid;
    logic [15:0]     rsp_result;
    logic            rsp_overflow;
    logic            rsp_error;
    logic            busy;
    logic            div_start;
    logic [15:0]     div_dividen;
    logic [15:0]     div_divisor;
    logic [15:0]     div_result;
    logic            div_overflow;
    logic            div_finish;

    division_scheduler #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req),
        .dividen_in(dividen_in), .divisor_in(divisor_in),
        .grant(grant), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_error(rsp_error), .busy(busy),
        .div_start(div_start), .div_dividen(div_dividen), .div_divisor(div_divisor),
        .div_result(div_result), .div_overflow(div_overflow), .div_finish(div_finish)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Signed Q8.8 quotient, truncating toward zero; {overflow, quotient}.
    function automatic logic [16:0] qdiv(input logic [15:0] a, input logic [15:0] b);
        longint n, d, q;
        n = longint'($signed(a)) * 256;
        d = longint'($signed(b));
        if (d == 0) return {1'b1, 16'h0000};
        q = n / d;
        if (q > 32767 || q < -32768) return {1'b1, q[15:0]};
        return {1'b0, q[15:0]};
    endfunction

    // Divider emulator: finish stays high until one cycle after the start edge is seen.
    logic s1, pend;
    int   ecnt;
    bit   lat_rand = 0;
    bit   nofin    = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            div_finish   <= 1'b0;
            div_result   <= '0;
            div_overflow <= 1'b0;
            s1           <= 1'b0;
            pend         <= 1'b0;
            ecnt         <= 0;
        end else begin
            s1   <= div_start;
            pend <= div_start && !s1;
            if (pend) begin
                div_finish <= 1'b0;
                ecnt       <= nofin ? 0 : (lat_rand ? int'($urandom_range(1, 30)) : 23);
            end else if (ecnt != 0) begin
                ecnt <= ecnt - 1;
                if (ecnt == 1) begin
                    {div_overflow, div_result} <= qdiv(div_dividen, div_divisor);
                    div_finish <= 1'b1;
                end
            end
        end
    end

    // Transaction model: one operation at a time, timeline keyed on cycle numbers.
    bit          m_idle = 1;
    int          m_ptr  = 0;
    int          m_win  = 0;
    int          m_t0   = 0;
    int          m_fin  = -1;
    bit          m_err  = 0;
    logic [15:0] m_a, m_b;
    logic [N-1:0] eg, ev;
    logic [16:0] eq;

    int          g_idx[$], g_cyc[$], r_cyc[$], r_vec[$];
    logic [15:0] r_res[$];
    bit          r_ovf[$], r_err[$];

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_grant", grant, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_div_start", div_start, 0);
            chk("rst_rsp_error", rsp_error, 0);
            chk("rst_rsp_overflow", rsp_overflow, 0);
            chk("rst_rsp_result", rsp_result, 0);
            chk("rst_div_dividen", div_dividen, 0);
            chk("rst_div_divisor", div_divisor, 0);
            m_idle = 1;
            m_ptr  = 0;
            m_fin  = -1;
        end else begin
            eg = '0;
            ev = '0;
            if (!m_idle && cyc == m_t0 + 1) eg[m_win] = 1'b1;
            if (!m_idle && m_fin >= 0 && cyc == m_fin + 1) ev[m_win] = 1'b1;
            chk("grant", grant, eg);
            chk("div_start", div_start, eg != 0);
            chk("busy", busy, !m_idle);
            chk("rsp_valid", rsp_valid, ev);
            chk("rsp_error", rsp_error, (ev != 0) && m_err);
            if (ev != 0) begin
                eq = m_err ? 17'h0 : qdiv(m_a, m_b);
                chk("rsp_result", rsp_result, eq[15:0]);
                chk("rsp_overflow", rsp_overflow, eq[16]);
            end
            if (!m_idle && cyc > m_t0) begin
                chk("div_dividen", div_dividen, m_a);
                chk("div_divisor", div_divisor, m_b);
            end
            if (grant != 0) begin
                for (int i = 0; i < N; i++) if (grant[i]) g_idx.push_back(i);
                g_cyc.push_back(cyc);
            end
            if (rsp_valid != 0) begin
                r_cyc.push_back(cyc);
                r_vec.push_back(int'(rsp_valid));
                r_res.push_back(rsp_result);
                r_ovf.push_back(rsp_overflow);
                r_err.push_back(rsp_error);
            end
            if (m_idle) begin
                if (req != 0) begin
                    for (int k = 0; k < N; k++) begin
                        if (req[(m_ptr + k) % N]) begin
                            m_win = (m_ptr + k) % N;
                            break;
                        end
                    end
                    m_idle = 0;
                    m_t0   = cyc;
                    m_fin  = -1;
                    m_err  = 0;
                    m_ptr  = (m_win + 1) % N;
                    m_a    = dividen_in[16*m_win +: 16];
                    m_b    = divisor_in[16*m_win +: 16];
                end
            end else if (m_fin < 0) begin
                if (cyc >= m_t0 + 3) begin
                    if (div_finish) begin
                        m_fin = cyc;
                        m_err = 0;
                    end
`ifdef DIV_TIMEOUT_EN
                    else if (cyc - (m_t0 + 3) == TMO) begin
                        m_fin = cyc;
                        m_err = 1;
                    end
`endif
                end
            end else if (cyc == m_fin + 1) begin
                m_idle = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        dividen_in[16*i +: 16] = a;
        divisor_in[16*i +: 16] = b;
    endtask

    task automatic wait_grants(input int n, input string name);
        int t = 0;
        while (g_idx.size() < n && t < 400) begin
            tick();
            t++;
        end
        chk({name, "_grant_wait"}, g_idx.size() >= n, 1);
    endtask

    task automatic wait_rsps(input int n, input string name);
        int t = 0;
        while (r_cyc.size() < n && t < 400) begin
            tick();
            t++;
        end
        chk({name, "_rsp_wait"}, r_cyc.size() >= n, 1);
    endtask

    task automatic rand_op(input int i);
        logic [15:0] a, b;
        a = 16'($urandom);
        b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 16'h03FF)) : 16'($urandom);
        set_op(i, a, b);
    endtask

    int rc, ng, nr, t;
    int rr_res[4] = '{'h0180, 'h0100, 'hFE80, 'hFC00};

    initial begin
        rst = 1'b1;
        req = '0;
        dividen_in = '0;
        divisor_in = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Single request, golden latency.
        tick();
        set_op(0, 16'h0300, 16'h0200);
        req = 4'b0001; rc = cyc; ng = g_idx.size(); nr = r_cyc.size();
        wait_grants(ng + 1, "t1");
        req = '0;
        wait_rsps(nr + 1, "t1");
        chk("t1_grant_idx", g_idx[ng], 0);
        chk("t1_grant_cycle", g_cyc[ng] - rc, 1);
        chk("t1_rsp_vec", r_vec[nr], 4'b0001);
        chk("t1_result", r_res[nr], 16'h0180);
        chk("t1_overflow", r_ovf[nr], 0);
        chk("t1_latency", r_cyc[nr] - rc, 27);

        // Negative dividend through requester 2.
        tick();
        set_op(2, 16'hFD00, 16'h0200);
        req = 4'b0100; ng = g_idx.size(); nr = r_cyc.size();
        wait_grants(ng + 1, "sign");
        req = '0;
        wait_rsps(nr + 1, "sign");
        chk("sign_rsp_vec", r_vec[nr], 4'b0100);
        chk("sign_result", r_res[nr], 16'hFE80);

        // Overflow through requester 3.
        tick();
        set_op(3, 16'h7F00, 16'h0001);
        req = 4'b1000; ng = g_idx.size(); nr = r_cyc.size();
        wait_grants(ng + 1, "ovf");
        req = '0;
        wait_rsps(nr + 1, "ovf");
        chk("ovf_rsp_vec", r_vec[nr], 4'b1000);
        chk("ovf_flag", r_ovf[nr], 1);

        // Round-robin with all four requesting; ptr is back at 0.
        tick();
        set_op(0, 16'h0300, 16'h0200);
        set_op(1, 16'h0100, 16'h0100);
        set_op(2, 16'hFD00, 16'h0200);
        set_op(3, 16'h0400, 16'hFF00);
        req = 4'b1111; ng = g_idx.size(); nr = r_cyc.size();
        wait_grants(ng + 5, "rr");
        req = '0;
        wait_rsps(nr + 5, "rr");
        for (int k = 0; k < 5; k++) begin
            chk("rr_grant_order", g_idx[ng + k], k % 4);
            chk("rr_rsp_vec", r_vec[nr + k], 1 << (k % 4));
            chk("rr_result", r_res[nr + k], rr_res[k % 4]);
            if (k > 0) chk("rr_grant_gap", g_cyc[ng + k] - r_cyc[nr + k - 1], 2);
        end

        // Reset ten cycles after a grant; ptr would otherwise be 3.
        tick();
        set_op(2, 16'h0500, 16'h0100);
        req = 4'b0100; ng = g_idx.size();
        wait_grants(ng + 1, "rstmid");
        req = '0;
        repeat (9) tick();
        rst = 1'b1;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_grant", grant, 0);
        chk("rstmid_div_dividen", div_dividen, 0);
        chk("rstmid_rsp_result", rsp_result, 0);
        nr = r_cyc.size();
        tick();
        tick();
        rst = 1'b0;
        repeat (30) tick();
        chk("rstmid_no_rsp", r_cyc.size(), nr);
        set_op(1, 16'h0200, 16'h0400);
        set_op(3, 16'h0100, 16'h0200);
        req = 4'b1010; ng = g_idx.size();
        wait_grants(ng + 1, "rstnext");
        req = '0;
        wait_rsps(nr + 1, "rstnext");
        chk("rstnext_grant_idx", g_idx[ng], 1);
        chk("rstnext_result", r_res[nr], 16'h0080);

`ifdef DIV_TIMEOUT_EN
        // Divider never finishes: watchdog answers with an error.
        nofin = 1;
        tick();
        set_op(0, 16'h0300, 16'h0200);
        req = 4'b0001; ng = g_idx.size(); nr = r_cyc.size();
        wait_grants(ng + 1, "tmo");
        req = '0;
        wait_rsps(nr + 1, "tmo");
        chk("tmo_error", r_err[nr], 1);
        chk("tmo_result", r_res[nr], 0);
        chk("tmo_delay", r_cyc[nr] - g_cyc[ng], TMO + 3);
        nofin = 0;
`endif

        // Randomized traffic with random divider latency.
        lat_rand = 1;
        for (int c = 0; c < 2500; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (req[i] && grant[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else rand_op(i);
                end else if (!req[i] && $urandom_range(0, 5) == 0) begin
                    rand_op(i);
                    req[i] = 1'b1;
                end
            end
        end
        req = '0;
        t = 0;
        while (busy && t < 200) begin
            tick();
            t++;
        end
        tick();
        chk("drain_busy", busy, 0);
        chk("drain_counts", r_cyc.size(), g_idx.size() - 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/division_scheduler.md
# division_scheduler

Shares the single fixed-point `division` unit between `N_REQ` requesters in the ODE accelerator. It does round-robin arbitration, latches the winner's Q8.8 operands, and sequences the divider's edge-triggered `start`. It also masks the divider's stale `finish` level and returns the result, overflow flag and requester index as a one-cycle response. It sits between the ODE step controllers and one `division` instance.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 48: maximum WAIT cycles. Used only with `DIV_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset. The same net drives the divider's `rst`.
- `req`  in  N_REQ  level requests. Bit i is held until `grant[i]`.
- `dividen_in`  in  16*N_REQ  operand per requester. Slice i is `[16i+15:16i]`. Q8.8 two's complement.
- `divisor_in`  in  16*N_REQ  divisor per requester, same packing.
- `grant`  out  N_REQ  one-hot, one-cycle pulse. Operands were captured at the previous edge.
- `rsp_valid`  out  N_REQ  one-hot, one-cycle pulse to the owner.
- `rsp_result`  out  16  quotient. Valid while `rsp_valid` is nonzero.
- `rsp_overflow`  out  1  divider overflow flag, latched with the result.
- `rsp_error`  out  1  timeout abort. Constant 0 without `DIV_TIMEOUT_EN`.
- `busy`  out  1  high in every state except IDLE.
- `div_start`  out  1  drives divider `start`.
- `div_dividen`, `div_divisor`  out  16  stable from ISSUE through DONE.
- `div_result`  in  16  divider result.
- `div_overflow`  in  1  divider overflow flag.
- `div_finish`  in  1  divider finish, a level.

## Operation
FSM states: IDLE, ISSUE, SETTLE, WAIT, DONE.

- **IDLE**
  - If `req` is nonzero, pick the first set bit at or above `ptr`, wrapping modulo N_REQ.
  - Latch the winner index and its operands.
  - Set `ptr` = winner+1, wrapping N_REQ-1 → 0.
  - Go to ISSUE.
- **ISSUE**: `grant[winner]`=1 and `div_start`=1 for exactly one cycle → SETTLE.
- **SETTLE**: `div_start`=0 and `div_finish` is ignored for one cycle. The divider clears its previous finish here. → WAIT.
- **WAIT**: on `div_finish`=1, latch `div_result` and `div_overflow` → DONE.
- **DONE**
  - `rsp_valid[winner]`=1, `rsp_error`=0, for one cycle.
  - Then go to IDLE.

Rules:
- `req` is sampled only in IDLE. A requester that is granted and re-requests competes in the next IDLE like any other requester.
- The scheduler performs no arithmetic on the quotient; sign handling stays inside the divider.
- `div_start` must produce exactly one rising edge per operation. It is registered and glitch-free.
- Any `req` bit set while `busy` is high simply waits.

## Timing
- Reset values, applied asynchronously:
  - state IDLE, `ptr`=0.
  - `grant`, `rsp_valid`, `div_start`, `busy`, `rsp_error`, `rsp_overflow` = 0.
  - `rsp_result`, `div_dividen`, `div_divisor` = 0.
- Cycle numbering, with cycle 0 being the first IDLE cycle in which `req` is seen:
  - `grant` and `div_start` are high in cycle 1.
  - SETTLE is cycle 2.
  - WAIT starts in cycle 3.
  - `rsp_valid` is high one cycle after `div_finish` is sampled high.
- With the divider's 23-iteration loop, a request-to-response latency of about 27 cycles is normal. The bench measures it exactly and records it as the golden value.
- After DONE, the next grant comes two cycles later at the earliest (DONE → IDLE → ISSUE).
- Asserting `rst` mid-operation aborts immediately. No `rsp_valid` is issued and `ptr` returns to 0.
- Deasserting `req` in the cycle of its grant is legal.

## Configuration
`DIV_TIMEOUT_EN`:
- **Defined:**
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT` without `div_finish`, go to DONE with `rsp_error`=1, `rsp_result`=0 and `rsp_overflow`=0.
- **Undefined:**
  - No counter is built. WAIT lasts until `div_finish`.
  - `rsp_error` is tied to 0.

## Test plan
- Single request: `req[0]`=1, 0x0300 / 0x0200 → `grant[0]` in cycle 1, one `div_start` edge, `rsp_valid`=0001, `rsp_result`=0x0180, `rsp_overflow`=0.
- Signs: requester 2 divides 0xFD00 by 0x0200 → `rsp_valid`=0100, `rsp_result`=0xFE80.
- Overflow: 0x7F00 / 0x0001 → `rsp_overflow`=1, `rsp_valid` pulse issued normally.
- Round-robin:
  - `req`=1111 held continuously gives grants in order 0,1,2,3,0.
  - Each requester gets its own quotient.
  - Each grant comes two cycles after the preceding `rsp_valid`.
- Reset mid-WAIT: assert `rst` ten cycles after the grant → all outputs 0 immediately, no `rsp_valid`. The next request to arrive is then granted normally, starting from `ptr`=0.
- With `DIV_TIMEOUT_EN` and `div_finish` forced to 0: `rsp_valid` arrives after `TIMEOUT`+1 WAIT cycles with `rsp_error`=1 and `rsp_result`=0. The FSM returns to IDLE.
